// File: rtl/i2c_slave_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regfile
// Brief    : I2C target with a pointer-addressed register bank, auto-increment
//            and repeated-START support. Optional I2C_SLV_GLITCH_FILTER_EN adds
//            a 3-sample majority filter after each input synchronizer.
// Revision : 1.0
// ============================================================================
module i2c_slave_regfile #(
  parameter logic [6:0] MY_ADDR  = 7'h36,
  parameter int         NUM_REGS = 10,
  parameter int         PTR_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     scl,
  inout  wire                      sda,
  input  logic [NUM_REGS-1:0][7:0] data_in,
  output logic [NUM_REGS-1:0][7:0] data_out,
  output logic                     wr_strobe,
  output logic [PTR_W-1:0]         wr_index,
  output logic                     busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_AACK, S_PTR, S_PACK, S_WDATA,
    S_WACK, S_RDATA, S_MACK, S_NACK, S_IGNORE
  } state_t;

  state_t           state, state_nx;
  logic [1:0]       scl_sync, sda_sync;
  logic             scl_f, sda_f, scl_d, sda_d;
  logic [2:0]       cnt;
  logic [7:0]       shreg, rd_sr;
  logic             phase, rnw, mack_nack, oe;
  logic [PTR_W-1:0] ptr;

  // Sync flops reset to the idle bus level so reset release never fakes an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  logic [2:0] scl_hist, sda_hist;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_hist <= 3'b111;
      sda_hist <= 3'b111;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[1]};
      sda_hist <= {sda_hist[1:0], sda_sync[1]};
    end
  end
  assign scl_f = (scl_hist[0] & scl_hist[1]) | (scl_hist[0] & scl_hist[2]) | (scl_hist[1] & scl_hist[2]);
  assign sda_f = (sda_hist[0] & sda_hist[1]) | (sda_hist[0] & sda_hist[2]) | (sda_hist[1] & sda_hist[2]);
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  logic       scl_rise, scl_fall, start_det, stop_det, byte_done, addr_hit, ptr_ok;
  logic [7:0] rx_byte;
  logic [PTR_W-1:0] ptr_inc;

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
  assign rx_byte   = {shreg[6:0], sda_f};
  assign byte_done = scl_rise && (cnt == 3'd7);
  assign addr_hit  = (rx_byte[7:1] == MY_ADDR);
  assign ptr_ok    = ({1'b0, rx_byte} < 9'(NUM_REGS));
  assign ptr_inc   = (ptr == PTR_W'(NUM_REGS - 1)) ? '0 : ptr + PTR_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Ack-type states use phase: first fall starts the slot, second fall ends it
  always_comb begin
    state_nx = state;
    if (start_det)     state_nx = S_ADDR;
    else if (stop_det) state_nx = S_IDLE;
    else begin
      case (state)
        S_ADDR:         if (byte_done) state_nx = addr_hit ? S_AACK : S_IGNORE;
        S_PTR:          if (byte_done) state_nx = ptr_ok ? S_PACK : S_NACK;
        S_WDATA:        if (byte_done) state_nx = S_WACK;
        S_RDATA:        if (byte_done) state_nx = S_MACK;
        S_AACK:         if (scl_fall && phase) state_nx = rnw ? S_RDATA : S_PTR;
        S_PACK, S_WACK: if (scl_fall && phase) state_nx = S_WDATA;
        S_MACK:         if (scl_fall && phase) state_nx = mack_nack ? S_IGNORE : S_RDATA;
        S_NACK:         if (scl_fall && phase) state_nx = S_IGNORE;
        default:        state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0; shreg <= '0; rd_sr <= '0; phase <= 1'b0; rnw <= 1'b0;
      mack_nack <= 1'b1; oe <= 1'b0; ptr <= '0; busy <= 1'b0;
      data_out <= '0; wr_strobe <= 1'b0; wr_index <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (start_det || stop_det) begin
        oe   <= 1'b0;
        busy <= 1'b0;
      end else begin
        case (state)
          S_ADDR, S_PTR, S_WDATA:
            if (scl_rise) begin
              shreg <= rx_byte;
              cnt   <= cnt + 3'd1;
            end
          S_RDATA:
            if (scl_rise) cnt <= cnt + 3'd1;
            else if (scl_fall) begin
              oe    <= ~rd_sr[7];
              rd_sr <= {rd_sr[6:0], 1'b0};
            end
          S_AACK, S_PACK, S_WACK, S_NACK:
            if (scl_fall && !phase) begin
              oe    <= (state != S_NACK);
              phase <= 1'b1;
            end
          S_MACK:
            if (scl_fall && !phase) begin
              oe    <= 1'b0;
              phase <= 1'b1;
            end else if (scl_rise && phase) mack_nack <= sda_f;
          default: ;
        endcase
        if (state == S_ADDR && byte_done) begin
          rnw <= sda_f;
          if (addr_hit) busy <= 1'b1;
        end
        if (state == S_PTR && byte_done && ptr_ok) ptr <= PTR_W'(rx_byte);
        if (state == S_WDATA && byte_done) begin
          data_out[ptr] <= rx_byte;
          wr_strobe     <= 1'b1;
          wr_index      <= ptr;
          ptr           <= ptr_inc;
        end
        if (state == S_RDATA && byte_done) ptr <= ptr_inc;
        // First read bit is driven on the same fall that enters RDATA
        if (state_nx == S_RDATA && state != S_RDATA) begin
          oe    <= ~data_in[ptr][7];
          rd_sr <= {data_in[ptr][6:0], 1'b0};
        end
        if (state_nx != state &&
            (state_nx == S_PTR || state_nx == S_WDATA || state_nx == S_IGNORE))
          oe <= 1'b0;
      end
      if (start_det || state_nx != state) begin
        cnt   <= '0;
        phase <= 1'b0;
      end
    end
  end

  // Gated by reset so the bus is released combinationally during reset
  assign sda = (oe && reset) ? 1'b0 : 1'bz;

endmodule
`default_nettype wire
